// File: rtl/rx_8b10b_link_decoder_if.sv
// PHY-side code-group bus and decoded output bundle
// for the 8b/10b link decoder.
interface rx_8b10b_link_decoder_if #(
  parameter int ERR_CNT_W = 16
);
  logic [9:0]           rx_parallel_data;
  logic                 rx_syncstatus;
  logic                 rx_patterndetect;
  logic                 err_count_clr;
  logic [7:0]           data_out;
  logic                 k_out;
  logic                 data_valid;
  logic                 code_err;
  logic                 disp_err;
  logic                 link_up;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output rx_parallel_data, rx_syncstatus,
    output rx_patterndetect, err_count_clr,
    input  data_out, k_out, data_valid,
    input  code_err, disp_err, link_up, err_count
  );

  modport slave (
    input  rx_parallel_data, rx_syncstatus,
    input  rx_patterndetect, err_count_clr,
    output data_out, k_out, data_valid,
    output code_err, disp_err, link_up, err_count
  );
endinterface

// File: rtl/rx_8b10b_link_decoder.sv
// 8b/10b decoder with running-disparity check,
// comma-based link sync FSM and error counter.
module rx_8b10b_link_decoder #(
  parameter int COMMA_REQ = 3,
  parameter int ERR_LIMIT = 4,
  parameter int GOOD_RUN  = 4,
  parameter int ERR_CNT_W = 16
) (
  input logic clock,
  input logic reset_n,
  rx_8b10b_link_decoder_if.slave rx
);
  localparam logic [1:0] LOSS = 2'd0;
  localparam logic [1:0] ACQ  = 2'd1;
  localparam logic [1:0] SYNC = 2'd2;
  localparam int NW = $clog2(COMMA_REQ + 1);
  localparam int CW = $clog2(ERR_LIMIT + 1);
  localparam int RW = $clog2(GOOD_RUN + 1);

  logic [9:0] cw_q, cw_d;
  logic sync_q, sync_d, clr_q, clr_d, v1_q, v1_d;
  logic [7:0] data_q, data_d;
  logic k_q, k_d, ce_q, ce_d, de_q, de_d;
  logic dv_q, dv_d, rd_q, rd_d;
  logic [1:0] st_q, st_d;
  logic [NW-1:0] n_q, n_d;
  logic [CW-1:0] cr_q, cr_d;
  logic [RW-1:0] run_q, run_d;
  logic [ERR_CNT_W-1:0] ec_q, ec_d;

  logic [5:0] s6;
  logic [3:0] s4, s4d;
  logic [4:0] lo5;
  logic [2:0] hi3, n6, n4;
  logic v6, v4, p7, a7, k28, kx7, am, ap;
  logic cerr, derr, kflag, bad, comma, rd_m, e6, e4;
  logic unused_pd;

  assign unused_pd = rx.rx_patterndetect;

  always_comb begin
    cw_d   = rx.rx_parallel_data;
    sync_d = rx.rx_syncstatus;
    clr_d  = rx.err_count_clr;
    v1_d   = 1'b1;
  end

  // bit 0 is 'a', the first bit on the line
  always_comb begin
    s6  = {cw_q[0], cw_q[1], cw_q[2],
           cw_q[3], cw_q[4], cw_q[5]};
    s4  = {cw_q[6], cw_q[7], cw_q[8], cw_q[9]};
    k28 = (s6 == 6'b001111) | (s6 == 6'b110000);
    s4d = (s6 == 6'b110000) ? ~s4 : s4;
    v6  = 1'b1;
    lo5 = 5'd0;
    case (s6)
      6'b100111, 6'b011000: lo5 = 5'd0;
      6'b011101, 6'b100010: lo5 = 5'd1;
      6'b101101, 6'b010010: lo5 = 5'd2;
      6'b110001:            lo5 = 5'd3;
      6'b110101, 6'b001010: lo5 = 5'd4;
      6'b101001:            lo5 = 5'd5;
      6'b011001:            lo5 = 5'd6;
      6'b111000, 6'b000111: lo5 = 5'd7;
      6'b111001, 6'b000110: lo5 = 5'd8;
      6'b100101:            lo5 = 5'd9;
      6'b010101:            lo5 = 5'd10;
      6'b110100:            lo5 = 5'd11;
      6'b001101:            lo5 = 5'd12;
      6'b101100:            lo5 = 5'd13;
      6'b011100:            lo5 = 5'd14;
      6'b010111, 6'b101000: lo5 = 5'd15;
      6'b011011, 6'b100100: lo5 = 5'd16;
      6'b100011:            lo5 = 5'd17;
      6'b010011:            lo5 = 5'd18;
      6'b110010:            lo5 = 5'd19;
      6'b001011:            lo5 = 5'd20;
      6'b101010:            lo5 = 5'd21;
      6'b011010:            lo5 = 5'd22;
      6'b111010, 6'b000101: lo5 = 5'd23;
      6'b110011, 6'b001100: lo5 = 5'd24;
      6'b100110:            lo5 = 5'd25;
      6'b010110:            lo5 = 5'd26;
      6'b110110, 6'b001001: lo5 = 5'd27;
      6'b001110:            lo5 = 5'd28;
      6'b101110, 6'b010001: lo5 = 5'd29;
      6'b011110, 6'b100001: lo5 = 5'd30;
      6'b101011, 6'b010100: lo5 = 5'd31;
      6'b001111, 6'b110000: lo5 = 5'd28;
      default:              v6  = 1'b0;
    endcase
    v4  = 1'b1;
    hi3 = 3'd0;
    p7  = 1'b0;
    a7  = 1'b0;
    case (s4d)
      4'b1011, 4'b0100: hi3 = 3'd0;
      4'b1001:          hi3 = 3'd1;
      4'b0101:          hi3 = 3'd2;
      4'b1100, 4'b0011: hi3 = 3'd3;
      4'b1101, 4'b0010: hi3 = 3'd4;
      4'b1010:          hi3 = 3'd5;
      4'b0110:          hi3 = 3'd6;
      4'b1110, 4'b0001: begin
        hi3 = 3'd7;
        p7  = 1'b1;
      end
      4'b0111, 4'b1000: begin
        hi3 = 3'd7;
        a7  = 1'b1;
      end
      default: v4 = 1'b0;
    endcase
  end

  // alternate .7 is legal only for K.x.7 and D17/18/20, D11/13/14
  always_comb begin
    kx7 = s6 inside {6'b111010, 6'b000101,
                     6'b110110, 6'b001001,
                     6'b101110, 6'b010001,
                     6'b011110, 6'b100001};
    am  = s6 inside {6'b100011, 6'b010011,
                     6'b001011};
    ap  = s6 inside {6'b110100, 6'b101100,
                     6'b011100};
    cerr = ~v6 | ~v4;
    if (a7 && !(k28 || kx7 ||
        (am && s4 == 4'b0111) ||
        (ap && s4 == 4'b1000)))
      cerr = 1'b1;
    if (p7 && (k28 ||
        (am && s4 == 4'b1110) ||
        (ap && s4 == 4'b0001)))
      cerr = 1'b1;
    kflag = k28 | (kx7 & a7);
  end

  // 111000/1100 need RD- and leave RD-; 000111/0011 the reverse
  always_comb begin
    n6   = 3'($countones(s6));
    n4   = 3'($countones(s4));
    e6   = 1'b0;
    rd_m = rd_q;
    if (s6 == 6'b111000) begin
      e6 = rd_q;  rd_m = 1'b0;
    end else if (s6 == 6'b000111) begin
      e6 = ~rd_q; rd_m = 1'b1;
    end else if (n6 > 3'd3) begin
      e6 = rd_q;  rd_m = 1'b1;
    end else if (n6 < 3'd3) begin
      e6 = ~rd_q; rd_m = 1'b0;
    end
    e4   = 1'b0;
    rd_d = rd_m;
    if (s4 == 4'b1100) begin
      e4 = rd_m;  rd_d = 1'b0;
    end else if (s4 == 4'b0011) begin
      e4 = ~rd_m; rd_d = 1'b1;
    end else if (n4 > 3'd2) begin
      e4 = rd_m;  rd_d = 1'b1;
    end else if (n4 < 3'd2) begin
      e4 = ~rd_m; rd_d = 1'b0;
    end
    if (!v1_q) rd_d = rd_q;
    derr  = (e6 | e4) & ~cerr;
    bad   = cerr | derr;
    comma = kflag & ~bad &
            ({hi3, lo5} == 8'hBC);
  end

  always_comb begin
    st_d  = st_q;
    n_d   = n_q;
    cr_d  = cr_q;
    run_d = run_q;
    if (v1_q && !sync_q) begin
      st_d = LOSS; n_d = '0;
      cr_d = '0;   run_d = '0;
    end else if (v1_q) begin
      unique case (1'b1)
        st_q == LOSS: begin
          if (comma) begin
            st_d = ACQ; n_d = NW'(1);
          end
        end
        st_q == ACQ: begin
          if (bad) begin
            st_d = LOSS; n_d = '0;
          end else if (comma) begin
            n_d = n_q + NW'(1);
            if (n_d == NW'(COMMA_REQ)) begin
              st_d = SYNC; n_d = '0;
              cr_d = '0;   run_d = '0;
            end
          end
        end
        st_q == SYNC: begin
          if (cr_q == CW'(ERR_LIMIT)) begin
            st_d = LOSS;
            cr_d = '0; run_d = '0;
          end else if (bad) begin
            cr_d  = cr_q + CW'(1);
            run_d = '0;
          end else if (run_q + RW'(1) >= RW'(GOOD_RUN)
                       && cr_q != '0) begin
            cr_d  = cr_q - CW'(1);
            run_d = '0;
          end else if (run_q != RW'(GOOD_RUN)) begin
            run_d = run_q + RW'(1);
          end
        end
        default: begin
          st_d = LOSS; n_d = '0;
          cr_d = '0;   run_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    data_d = (v1_q && !cerr) ? {hi3, lo5} : 8'h00;
    k_d    = v1_q & ~cerr & kflag;
    ce_d   = v1_q & cerr;
    de_d   = v1_q & derr;
    dv_d   = v1_q & ~bad & (st_q == SYNC) &
             (st_d == SYNC);
    ec_d   = ec_q;
    if (v1_q && bad && !(&ec_q))
      ec_d = ec_q + ERR_CNT_W'(1);
    if (clr_q) ec_d = '0;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cw_q <= '0;  sync_q <= 1'b0;
      clr_q <= 1'b0; v1_q <= 1'b0;
      data_q <= '0; k_q <= 1'b0;
      ce_q <= 1'b0; de_q <= 1'b0;
      dv_q <= 1'b0; rd_q <= 1'b0;
      st_q <= LOSS; n_q <= '0;
      cr_q <= '0;  run_q <= '0;
      ec_q <= '0;
    end else begin
      cw_q <= cw_d;  sync_q <= sync_d;
      clr_q <= clr_d; v1_q <= v1_d;
      data_q <= data_d; k_q <= k_d;
      ce_q <= ce_d;  de_q <= de_d;
      dv_q <= dv_d;  rd_q <= rd_d;
      st_q <= st_d;  n_q <= n_d;
      cr_q <= cr_d;  run_q <= run_d;
      ec_q <= ec_d;
    end
  end

  assign rx.data_out   = data_q;
  assign rx.k_out      = k_q;
  assign rx.code_err   = ce_q;
  assign rx.disp_err   = de_q;
  assign rx.data_valid = dv_q;
  assign rx.link_up    = (st_q == SYNC);
  assign rx.err_count  = ec_q;
endmodule
